// File: rtl/raiz_seq.sv
// Sequencer wrapping a 32-bit square-root core: accept radicand, pulse core_init, wait for core_done or timeout.
// Result appears the cycle after core_done and is held in HOLD until out_ready; in_ready only in IDLE.
module raiz_seq #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        core_init,
  output logic [31:0] core_a,
  input  logic        core_done,
  input  logic [31:0] core_q,
  input  logic [31:0] core_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic [31:0] out_r,
  output logic        out_err,
  output logic        busy
);

  // One spare bit so the terminal count is representable even for TIMEOUT a power of two.
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [31:0]    a_reg;
  logic [TW-1:0]  timer;
  logic           timer_last;

  assign timer_last = (timer == TW'(TIMEOUT - 1));
  assign core_a     = a_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    core_init = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = S_START;
      end
      S_START: begin
        core_init = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        if (core_done || timer_last) state_nx = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // a_reg only loads in IDLE, so core_a is stable for the whole operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= 32'd0;
      timer   <= '0;
      out_q   <= 32'd0;
      out_r   <= 32'd0;
      out_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) a_reg <= in_data;
        end
        S_START: begin
          timer <= '0;
        end
        S_WAIT: begin
          if (core_done) begin
            out_q   <= core_q;
            out_r   <= core_r;
            out_err <= 1'b0;
          end else if (timer_last) begin
            out_q   <= 32'd0;
            out_r   <= 32'd0;
            out_err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raiz_seq.sv
// Directed bench for raiz_seq with a behavioural square-root core (done 17 cycles after init by default).
module tb_raiz_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        core_init;
  logic [31:0] core_a;
  logic        core_done;
  logic [31:0] core_q;
  logic [31:0] core_r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic [31:0] out_r;
  logic        out_err;
  logic        busy;

  int total;
  int bad;
  int lat;

  // core model controls
  int          dly;
  logic        never;
  logic        force_done;
  logic        model_done;
  logic        armed;
  int          cnt;
  logic [31:0] a_lat;

  raiz_seq #(.TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .core_init (core_init),
    .core_a    (core_a),
    .core_done (core_done),
    .core_q    (core_q),
    .core_r    (core_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign core_done = model_done | force_done;

  function automatic logic [31:0] isqrt(input logic [31:0] a);
    logic [63:0] q;
    logic [63:0] t;
    q = 64'd0;
    for (int b = 15; b >= 0; b--) begin
      t = q | (64'd1 << b);
      if (t * t <= {32'd0, a}) q = t;
    end
    return q[31:0];
  endfunction

  // Core model works on the falling edge so its outputs are settled well before the DUT samples them.
  always @(negedge clk) begin
    if (core_init) begin
      armed      = !never;
      cnt        = dly;
      a_lat      = core_a;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (armed) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          armed      = 1'b0;
          model_done = 1'b1;
          core_q     = isqrt(a_lat);
          core_r     = a_lat - core_q * core_q;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers a radicand for one edge, then counts cycles until out_valid (bounded).
  task automatic run_op(input logic [31:0] d, output int n);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 32'd0;
    out_ready = 1'b1;
    dly = 17;
    never = 1'b0;
    force_done = 1'b0;
    model_done = 1'b0;
    armed = 1'b0;
    cnt = 0;
    a_lat = 32'd0;
    core_q = 32'd0;
    core_r = 32'd0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_init", core_init, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_core_a", core_a, 0);

    // radicand 100: check START cycle, then 18 cycles to out_valid
    in_data  = 32'd100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("start_core_init", core_init, 1);
    chk("start_in_ready", in_ready, 0);
    chk("start_busy", busy, 1);
    chk("start_core_a", core_a, 100);
    tick();
    chk("wait_core_init", core_init, 0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("r100_latency", lat, 18);
    chk("r100_q", out_q, 10);
    chk("r100_r", out_r, 0);
    chk("r100_err", out_err, 0);
    tick();
    chk("r100_idle_valid", out_valid, 0);
    chk("r100_idle_ready", in_ready, 1);

    run_op(32'hFFFF_FFFF, lat);
    chk("rmax_latency", lat, 18);
    chk("rmax_q", out_q, 65535);
    chk("rmax_r", out_r, 131070);
    tick();

    run_op(32'd0, lat);
    chk("r0_latency", lat, 18);
    chk("r0_q", out_q, 0);
    chk("r0_r", out_r, 0);
    tick();

    // radicand 50 with consumer stalled for 5 cycles
    out_ready = 1'b0;
    run_op(32'd50, lat);
    chk("r50_latency", lat, 18);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_q", out_q, 7);
      chk("hold_r", out_r, 1);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    chk("hold_still_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("hold_release_valid", out_valid, 0);
    chk("hold_release_ready", in_ready, 1);

    // core never answers: 64 WAIT cycles then error result
    never = 1'b1;
    run_op(32'd81, lat);
    chk("to_latency", lat, 65);
    chk("to_err", out_err, 1);
    chk("to_q", out_q, 0);
    chk("to_r", out_r, 0);
    tick();
    never = 1'b0;

    // done lands on the 64th WAIT cycle: done wins
    dly = 64;
    run_op(32'd200, lat);
    chk("edge_latency", lat, 65);
    chk("edge_err", out_err, 0);
    chk("edge_q", out_q, 14);
    chk("edge_r", out_r, 4);
    tick();
    dly = 17;

    // stray core_done in IDLE
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_valid", out_valid, 0);
    chk("idle_done_q", out_q, 14);
    tick();
    chk("idle_done_valid2", out_valid, 0);

    // reset mid-WAIT, late core_done must be ignored
    in_data  = 32'd300;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_q", out_q, 0);
    chk("mrst_out_err", out_err, 0);
    chk("mrst_core_a", core_a, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("late_done_valid", out_valid, 0);
    end
    chk("late_done_busy", busy, 0);
    chk("late_done_q", out_q, 0);

    run_op(32'd16, lat);
    chk("r16_latency", lat, 18);
    chk("r16_q", out_q, 4);
    chk("r16_r", out_r, 0);
    chk("r16_err", out_err, 0);
    tick();
    chk("r16_idle", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
